// File: rtl/arith_pkg.sv
// Shared arithmetic types and helpers for the ALU datapath units.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    // Counter wide enough to hold an iteration count of 0..width inclusive.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cla_subtractor_nbit.sv
// N-bit subtractor built as a + ~b + 1 on 4-bit carry-lookahead groups.
module cla_subtractor_nbit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_n
);

    localparam int NG = (N + 3) / 4;
    localparam int NP = NG * 4;

    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP-1:0] cin;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG-1:0] gc;

    // Sum-of-products carry out of the low 'upto' bits of a 4-bit group.
    function automatic logic look(input logic [3:0] gv, input logic [3:0] pv,
                                  input logic ci, input int upto);
        logic c;
        logic term;
        c    = 1'b0;
        term = ci;
        for (int m = 0; m < upto; m++) term = term & pv[m];
        c = term;
        for (int j = 0; j < upto; j++) begin
            term = gv[j];
            for (int m = j + 1; m < upto; m++) term = term & pv[m];
            c = c | term;
        end
        return c;
    endfunction

    always_comb begin
        g = '0;
        p = '0;
        for (int i = 0; i < N; i++) begin
            g[i] = a[i] & ~b[i];
            p[i] = a[i] ^ ~b[i];
        end
    end

    always_comb begin
        logic cc;
        gg = '0;
        gp = '0;
        gc = '0;
        cc = 1'b1;
        for (int grp = 0; grp < NG; grp++) begin
            gg[grp] = look(g[grp*4 +: 4], p[grp*4 +: 4], 1'b0, 4);
            gp[grp] = &p[grp*4 +: 4];
            gc[grp] = cc;
            cc      = gg[grp] | (gp[grp] & cc);
        end
    end

    always_comb begin
        cin = '0;
        for (int grp = 0; grp < NG; grp++) begin
            for (int k = 0; k < 4; k++) begin
                cin[grp*4 + k] = look(g[grp*4 +: 4], p[grp*4 +: 4], gc[grp], k);
            end
        end
    end

    assign diff     = p[N-1:0] ^ cin[N-1:0];
    // Carry out of bit N-1 may sit inside a padded group, so look it up directly.
    assign borrow_n = look(g[((N-1)/4)*4 +: 4], p[((N-1)/4)*4 +: 4],
                           gc[(N-1)/4], ((N-1) % 4) + 1);

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, results held until the next accepted start.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   diff;
    logic             take_t;
    logic             borrow_unused;

    // The partial remainder stays below the divisor, so its MSB is only
    // materialised in the shifted operand feeding the subtractor.
    assign p_shift = {p_q, a_q[WIDTH-1]};
    assign take_t  = ~diff[WIDTH];

    cla_subtractor_nbit #(
        .N(WIDTH + 1)
    ) u_sub (
        .a       (p_shift),
        .b       ({1'b0, b_q}),
        .diff    (diff),
        .borrow_n(borrow_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = dividend;
                        b_d     = divisor;
                        p_d     = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                a_d   = {a_q[WIDTH-2:0], take_t};
                p_d   = take_t ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = a_d;
                    rem_d   = p_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working operands carry no meaning outside RUN and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8) with directed vectors.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 with q=%0d r=%0d, required no done",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
            end
        end
    end

    // Drive a start for one edge; 'now' issues it at the current negedge.
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz,
                         input bit now);
        if (!now) @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        if (push) sb.push_back('{q: eq, r: er, dz: edz});
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
    endtask

    // Count negedges after the start edge until done; check latency and busy.
    task automatic wait_result(input string name, input int n0, input int busy0,
                               input int exp_n, input int exp_busy);
        int  n;
        int  bc;
        bit  got;
        n   = n0;
        bc  = busy0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bc++;
            if (done === 1'b1) got = 1'b1;
        end
        chk({name, "_latency"}, n, exp_n);
        chk({name, "_busy_cycles"}, bc, exp_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        issue(8'd100, 8'd7, 1, 8'd14, 8'd2, 0, 0);
        wait_result("100_7", 0, 0, W + 1, W);

        issue(8'd255, 8'd1, 1, 8'd255, 8'd0, 0, 0);
        wait_result("255_1", 0, 0, W + 1, W);
        issue(8'd5, 8'd9, 1, 8'd0, 8'd5, 0, 1);
        wait_result("5_9_b2b", 0, 0, W + 1, W);

        issue(8'd37, 8'd0, 1, 8'd255, 8'd37, 1, 0);
        wait_result("37_0", 0, 0, 1, 0);

        issue(8'd200, 8'd3, 1, 8'd66, 8'd2, 0, 0);
        repeat (3) @(negedge clk);
        chk("hold_quotient", quotient, 255);
        chk("hold_remainder", remainder, 37);
        chk("run_dbz_cleared", div_by_zero, 0);
        dividend = 8'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_result("200_3_ignore", 4, 4, W + 1, W);
        repeat (3) @(negedge clk);
        chk("no_extra_done_sb", sb.size(), 0);

        issue(8'd123, 8'd4, 0, 8'd0, 8'd0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        repeat (12) @(negedge clk);
        issue(8'd123, 8'd4, 1, 8'd30, 8'd3, 0, 0);
        wait_result("123_4", 0, 0, W + 1, W);

        issue(8'd255, 8'd255, 1, 8'd1, 8'd0, 0, 0);
        wait_result("255_255", 0, 0, W + 1, W);
        issue(8'd254, 8'd16, 1, 8'd15, 8'd14, 0, 0);
        wait_result("254_16", 0, 0, W + 1, W);
        issue(8'd1, 8'd255, 1, 8'd0, 8'd1, 0, 0);
        wait_result("1_255", 0, 0, W + 1, W);
        issue(8'd0, 8'd5, 1, 8'd0, 8'd0, 0, 0);
        wait_result("0_5", 0, 0, W + 1, W);
        issue(8'd0, 8'd0, 1, 8'd255, 8'd0, 1, 0);
        wait_result("0_0", 0, 0, 1, 0);

        repeat (4) @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
